bfp_decomp_arbiter: RTL

- Packet-level round-robin arbiter that shares one BFP decompression gearbox between N_PORTS AXI-Stream U-plane sources (per eAxC / antenna streams).
- Sits directly upstream of the gearbox slave port.
- Locks a grant from the first beat of a packet to its TLAST and forwards the granted stream unchanged, including the udCompHdr on TUSER.
- Provides enable/drain control and status/error outputs to the control plane.

---
 rtl/bfp_decomp_arbiter_if.sv | 35 +++
 rtl/bfp_decomp_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bfp_decomp_arbiter_if.sv
// Stream bundle between the U-plane sources, the arbiter and the BFP decompression gearbox.
// The slave modport is the arbiter's view. The master modport is the view of the sources plus the gearbox.
interface bfp_decomp_arbiter_if #(
   parameter int N_PORTS = 4,
   parameter int IDX_W   = $clog2(N_PORTS)
);
   logic [N_PORTS*64-1:0] s_axis_tdata;
   logic [N_PORTS*8-1:0]  s_axis_tkeep;
   logic [N_PORTS-1:0]    s_axis_tvalid;
   logic [N_PORTS-1:0]    s_axis_tlast;
   logic [N_PORTS*40-1:0] s_axis_tuser;
   logic [N_PORTS-1:0]    s_axis_tready;

   logic [63:0]           m_axis_tdata;
   logic [7:0]            m_axis_tkeep;
   logic                  m_axis_tvalid;
   logic                  m_axis_tlast;
   logic [39:0]           m_axis_tuser;
   logic                  m_axis_tready;
   logic [IDX_W-1:0]      m_axis_tid;

   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
      input  m_axis_tready
   );

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
      output m_axis_tready
   );
endinterface

// File: rtl/bfp_decomp_arbiter.sv
// Packet-level round-robin arbiter that feeds N U-plane streams into one BFP decompression gearbox.
// A grant is held from the first beat of a packet to its TLAST. Data passes through combinationally, with no buffering.
module bfp_decomp_arbiter #(
   parameter int N_PORTS = 4,
   parameter int IDX_W   = $clog2(N_PORTS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   bfp_decomp_arbiter_if.slave bus,
   output logic                busy,
   output logic [15:0]         pkt_count,
   output logic                err_comp_meth
);
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic             first_q, first_d;
   logic             err_q, err_d;
   logic [15:0]      pkt_count_q, pkt_count_d;

   logic [63:0]      port_tdata [N_PORTS];
   logic [7:0]       port_tkeep [N_PORTS];
   logic [39:0]      port_tuser [N_PORTS];

   logic             arb_found;
   logic [IDX_W-1:0] arb_idx;
   logic [IDX_W:0]   arb_cand;
   logic             m_valid;
   logic             m_hs;
   logic             bad_meth;
   logic [N_PORTS-1:0] s_tready;

   genvar gi;
   generate
      for (gi = 0; gi < N_PORTS; gi++) begin : g_port
         assign port_tdata[gi] = bus.s_axis_tdata[gi*64 +: 64];
         assign port_tkeep[gi] = bus.s_axis_tkeep[gi*8 +: 8];
         assign port_tuser[gi] = bus.s_axis_tuser[gi*40 +: 40];
      end
   endgenerate

   // Search last_grant+1, +2, ... with wrap-around. The first requester found wins.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_cand  = '0;
      for (int i = 1; i <= N_PORTS; i++) begin
         arb_cand = {1'b0, last_grant_q} + (IDX_W+1)'(i);
         if (arb_cand >= (IDX_W+1)'(N_PORTS)) begin
            arb_cand = arb_cand - (IDX_W+1)'(N_PORTS);
         end
         if (!arb_found && bus.s_axis_tvalid[arb_cand[IDX_W-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand[IDX_W-1:0];
         end
      end
   end

   assign m_valid  = (state_q == LOCKED) && bus.s_axis_tvalid[grant_q];
   assign m_hs     = m_valid && bus.m_axis_tready;
   // udCompMeth 0000 and 0001 are the only methods the gearbox understands.
   assign bad_meth = (port_tuser[grant_q][35:33] != 3'b000);

   always_comb begin
      s_tready = '0;
      if (state_q == LOCKED) begin
         s_tready[grant_q] = bus.m_axis_tready;
      end
   end

   assign bus.s_axis_tready = s_tready;
   assign bus.m_axis_tvalid = m_valid;
   assign bus.m_axis_tdata  = port_tdata[grant_q];
   assign bus.m_axis_tkeep  = port_tkeep[grant_q];
   assign bus.m_axis_tuser  = port_tuser[grant_q];
   assign bus.m_axis_tlast  = bus.s_axis_tlast[grant_q];
   assign bus.m_axis_tid    = grant_q;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      first_d      = first_q;
      pkt_count_d  = pkt_count_q;
      err_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && arb_found) begin
               state_d = LOCKED;
               grant_d = arb_idx;
               first_d = 1'b1;
            end
         end
         LOCKED: begin
            if (m_hs) begin
               first_d = 1'b0;
               err_d   = first_q && bad_meth;
               if (bus.s_axis_tlast[grant_q]) begin
                  state_d      = IDLE;
                  last_grant_d = grant_q;
                  pkt_count_d  = pkt_count_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(N_PORTS - 1);
         first_q      <= 1'b0;
         err_q        <= 1'b0;
         pkt_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         first_q      <= first_d;
         err_q        <= err_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

   assign busy          = (state_q == LOCKED);
   assign pkt_count     = pkt_count_q;
   assign err_comp_meth = err_q;
endmodule
